core_scheduler: RTL and testbench

//   Per-core control FSM. Sequences one instruction at a time through

---
 rtl/core_scheduler.sv | 138 +++++++++++++
 tb/tb_core_scheduler.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_scheduler.sv
// ----------------------------------------------------------------------------
// core_scheduler
//   Per-core control FSM. Moves one instruction at a time through
//   FETCH -> DECODE -> REQUEST -> WAIT -> EXECUTE -> UPDATE. It also owns the
//   shared PC, RET completion, an LSU watchdog and a retired-instruction
//   counter. core_state goes straight out to the register file, ALU, LSUs and
//   fetcher. It also serves as the debug view of the FSM.
//
// Ports
//   clk            in   1                  core clock, rising-edge
//   reset          in   1                  synchronous, active-high
//   start          in   1                  launch block (sampled in IDLE only)
//   instr_valid    in   1                  fetcher holds instr at current_pc
//   decoded_mem    in   1                  decoded instr is LDR/STR
//   decoded_ret    in   1                  decoded instr is RET
//   lsu_waiting    in   THREADS_PER_BLOCK  per-lane LSU request outstanding
//   next_pc        in   PC_BITS            next PC from thread 0 PC unit
//   core_state     out  3                  current FSM state encoding
//   current_pc     out  PC_BITS            PC of instruction in flight
//   done           out  1                  block finished (RET or error), sticky
//   error          out  1                  LSU watchdog expired, sticky
//   retired_count  out  8                  completed instructions, wraps
//
// Handshake: the fetcher's instr_valid is a level-sensitive valid. It is
// consumed on the FETCH cycle where it is high. There is no back-pressure
// ready, because the scheduler is always ready in FETCH.
// ----------------------------------------------------------------------------
module core_scheduler #(
    parameter int THREADS_PER_BLOCK = 4,
    parameter int PC_BITS           = 8,
    parameter int WAIT_TIMEOUT      = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         instr_valid,
    input  logic                         decoded_mem,
    input  logic                         decoded_ret,
    input  logic [THREADS_PER_BLOCK-1:0] lsu_waiting,
    input  logic [PC_BITS-1:0]           next_pc,
    output logic [2:0]                   core_state,
    output logic [PC_BITS-1:0]           current_pc,
    output logic                         done,
    output logic                         error,
    output logic [7:0]                   retired_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'b000,
        S_FETCH   = 3'b001,
        S_DECODE  = 3'b010,
        S_REQUEST = 3'b011,
        S_WAIT    = 3'b100,
        S_EXECUTE = 3'b101,
        S_UPDATE  = 3'b110,
        S_DONE    = 3'b111
    } state_t;

    // Wide enough to hold WAIT_TIMEOUT-1 for any WAIT_TIMEOUT >= 1.
    localparam int            CW        = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(WAIT_TIMEOUT - 1);

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] wait_cnt;
    logic          lsu_busy;
    logic          wait_expired;

    // lsu_waiting only matters for memory instructions. If the lanes clear on
    // the last permitted cycle, lsu_busy is low and the instruction proceeds.
    assign lsu_busy     = decoded_mem && (lsu_waiting != '0);
    assign wait_expired = lsu_busy && (wait_cnt == WAIT_LAST);

    assign core_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_FETCH;
            S_FETCH:   if (instr_valid) state_next = S_DECODE;
            S_DECODE:  state_next = S_REQUEST;
            S_REQUEST: state_next = S_WAIT;
            S_WAIT: begin
                if (!lsu_busy) begin
                    state_next = S_EXECUTE;
                end else if (wait_expired) begin
                    state_next = S_DONE;
                end
            end
            S_EXECUTE: state_next = S_UPDATE;
            S_UPDATE:  state_next = decoded_ret ? S_DONE : S_FETCH;
            S_DONE:    state_next = S_DONE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath registers. They change only in the states that own them, so a
    // reset mid-instruction simply discards any partial work.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_pc    <= '0;
            done          <= 1'b0;
            error         <= 1'b0;
            retired_count <= 8'd0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                S_REQUEST: wait_cnt <= '0;
                S_WAIT: begin
                    if (wait_expired) begin
                        error <= 1'b1;
                        done  <= 1'b1;
                    end else if (lsu_busy) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_UPDATE: begin
                    retired_count <= retired_count + 8'd1;
                    if (decoded_ret) begin
                        done <= 1'b1;
                    end else begin
                        current_pc <= next_pc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_scheduler.sv
// ----------------------------------------------------------------------------
// tb_core_scheduler
//   Drives core_scheduler one instruction at a time from a plan with these
//   fields: fetch stalls, mem or not, LSU busy cycles, ret, next_pc, and an
//   optional reset abort. From the same plan it predicts the visible state
//   trace and register values. Each cycle's prediction goes into exp_q, and
//   a negedge process compares it with the DUT.
// ----------------------------------------------------------------------------
module tb_core_scheduler;

  localparam int THREADS      = 4;
  localparam int PC_BITS      = 8;
  localparam int WAIT_TIMEOUT = 64;
  localparam int W            = 21;  // {state[3], pc[8], done, error, count[8]}

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_REQUEST = 3'd3;
  localparam logic [2:0] S_WAIT    = 3'd4;
  localparam logic [2:0] S_EXEC    = 3'd5;
  localparam logic [2:0] S_UPDATE  = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset;
  logic               start;
  logic               instr_valid;
  logic               decoded_mem;
  logic               decoded_ret;
  logic [THREADS-1:0] lsu_waiting;
  logic [PC_BITS-1:0] next_pc;
  logic [2:0]         core_state;
  logic [PC_BITS-1:0] current_pc;
  logic               done;
  logic               error;
  logic [7:0]         retired_count;

  core_scheduler #(
    .THREADS_PER_BLOCK(THREADS),
    .PC_BITS(PC_BITS),
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .instr_valid(instr_valid),
    .decoded_mem(decoded_mem),
    .decoded_ret(decoded_ret),
    .lsu_waiting(lsu_waiting),
    .next_pc(next_pc),
    .core_state(core_state),
    .current_pc(current_pc),
    .done(done),
    .error(error),
    .retired_count(retired_count)
  );

  // ---------------- model state ----------------
  logic [7:0] m_pc;
  logic       m_done;
  logic       m_err;
  logic [7:0] m_cnt;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      logic [W-1:0] a;
      e = exp_q.pop_front();
      a = {core_state, current_pc, done, error, retired_count};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_trace t=%0t: got state=%0d pc=%0d done=%0b err=%0b cnt=%0d, want state=%0d pc=%0d done=%0b err=%0b cnt=%0d",
                 $time, a[20:18], a[17:10], a[9], a[8], a[7:0],
                 e[20:18], e[17:10], e[9], e[8], e[7:0]);
      end
    end
  end

  task automatic check_lit(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp_v);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one cycle. Then record what the DUT must show in the state it
  // has just entered.
  task automatic step(input logic [2:0] st);
    @(posedge clk);
    #1;
    exp_q.push_back({st, m_pc, m_done, m_err, m_cnt});
  endtask

  // Randomise every input. Callers then override the ones the current
  // state actually samples.
  task automatic junk();
    start       = 1'($urandom_range(0, 1));
    instr_valid = 1'($urandom_range(0, 1));
    decoded_mem = 1'($urandom_range(0, 1));
    decoded_ret = 1'($urandom_range(0, 1));
    lsu_waiting = 4'($urandom_range(0, 15));
    next_pc     = 8'($urandom_range(0, 255));
  endtask

  // Call with reset already high in the current cycle. Returns with the
  // DUT visibly in IDLE and reset released.
  task automatic reset_seq();
    m_pc = 8'd0; m_done = 1'b0; m_err = 1'b0; m_cnt = 8'd0;
    step(S_IDLE);
    junk();
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      step(S_IDLE);
      junk();
      start = 1'b0;
    end
  endtask

  task automatic hold_done(input int n);
    for (int i = 0; i < n; i++) begin
      step(S_DONE);
      junk();  // includes random start pulses, which must be ignored
    end
  endtask

  // One instruction. Call with the DUT about to enter FETCH on the next edge.
  // status: 0 = back to FETCH, 1 = RET -> DONE, 2 = watchdog -> DONE,
  //         3 = reset asserted in state abort_st.
  task automatic run_instr(input int stall, input bit mem, input int busy,
                           input bit ret, input logic [7:0] npc,
                           input int abort_st,
                           output int status, output int wait_n);
    status = 0;
    wait_n = 0;
    for (int i = 0; i <= stall; i++) begin
      step(S_FETCH); junk();
      instr_valid = (i == stall);
      if (abort_st == 1) begin reset = 1'b1; status = 3; return; end
    end
    step(S_DECODE); junk();
    if (abort_st == 2) begin reset = 1'b1; status = 3; return; end
    step(S_REQUEST); junk();
    if (abort_st == 3) begin reset = 1'b1; status = 3; return; end
    for (int j = 0; j < WAIT_TIMEOUT; j++) begin
      step(S_WAIT); junk();
      wait_n++;
      if (abort_st == 4) begin reset = 1'b1; status = 3; return; end
      decoded_mem = mem;
      if (!mem) break;
      lsu_waiting = (j < busy) ? 4'($urandom_range(1, 15)) : 4'b0000;
      if (j >= busy) break;
      if (j == WAIT_TIMEOUT - 1) begin
        m_done = 1'b1; m_err = 1'b1; status = 2; return;
      end
    end
    step(S_EXEC); junk();
    if (abort_st == 5) begin reset = 1'b1; status = 3; return; end
    step(S_UPDATE); junk();
    if (abort_st == 6) begin reset = 1'b1; status = 3; return; end
    decoded_ret = ret;
    next_pc     = npc;
    m_cnt = m_cnt + 8'd1;
    if (ret) begin
      m_done = 1'b1;
      status = 1;
    end else begin
      m_pc = npc;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int st;
    int wn;
    reset = 1'b1; start = 1'b0; instr_valid = 1'b0; decoded_mem = 1'b0;
    decoded_ret = 1'b0; lsu_waiting = '0; next_pc = '0;
    m_pc = 8'd0; m_done = 1'b0; m_err = 1'b0; m_cnt = 8'd0;
    repeat (3) @(posedge clk);
    reset_seq();
    check_lit("reset_state", core_state, 0);
    check_lit("reset_pc", current_pc, 0);
    check_lit("reset_flags", {done, error}, 0);
    check_lit("reset_count", retired_count, 0);

    // T1 + T2: a plain instruction, then one with three fetch stalls.
    idle_cycles(2);
    start = 1'b1;
    run_instr(0, 1'b0, 0, 1'b0, 8'd5, 0, st, wn);
    check_lit("t1_model_pc", m_pc, 5);
    check_lit("t1_model_cnt", m_cnt, 1);
    check_lit("t1_wait_cycles", wn, 1);
    run_instr(3, 1'b0, 0, 1'b0, 8'd9, 0, st, wn);

    // T3: LSU busy for 4 WAIT cycles gives 5 WAIT cycles, no error.
    run_instr(0, 1'b1, 4, 1'b0, 8'd9, 0, st, wn);
    check_lit("t3_wait_cycles", wn, 5);
    check_lit("t3_status", st, 0);

    // Lanes clear on the final permitted cycle, so the instruction proceeds.
    run_instr(0, 1'b1, WAIT_TIMEOUT - 1, 1'b0, 8'd9, 0, st, wn);
    check_lit("edge_wait_cycles", wn, 64);
    check_lit("edge_status", st, 0);

    // T5: RET with current_pc = 9, then start pulses in DONE, then reset.
    run_instr(1, 1'b0, 0, 1'b1, 8'd77, 0, st, wn);
    check_lit("t5_status", st, 1);
    hold_done(4);
    check_lit("t5_state", core_state, 7);
    check_lit("t5_pc", current_pc, 9);
    check_lit("t5_done", done, 1);
    reset = 1'b1;
    reset_seq();
    check_lit("t5_reset_state", core_state, 0);
    check_lit("t5_reset_done", done, 0);

    // T4: watchdog expiry.
    start = 1'b1;
    run_instr(0, 1'b1, 100, 1'b0, 8'd3, 0, st, wn);
    check_lit("t4_status", st, 2);
    check_lit("t4_wait_cycles", wn, 64);
    hold_done(20);
    check_lit("t4_state", core_state, 7);
    check_lit("t4_error", error, 1);
    check_lit("t4_done", done, 1);
    reset = 1'b1;
    reset_seq();

    // T6: reset in WAIT, then reset in UPDATE.
    start = 1'b1;
    run_instr(0, 1'b1, 3, 1'b0, 8'd4, 4, st, wn);
    reset_seq();
    start = 1'b1;
    run_instr(0, 1'b0, 0, 1'b0, 8'd4, 0, st, wn);
    run_instr(0, 1'b0, 0, 1'b0, 8'd6, 6, st, wn);
    reset_seq();
    check_lit("t6_abort_count", retired_count, 0);

    // T6: 256 retirements wrap the counter. The 257th is a RET.
    start = 1'b1;
    for (int k = 0; k < 256; k++) begin
      run_instr($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                $urandom_range(0, 2), 1'b0, 8'($urandom_range(0, 255)),
                0, st, wn);
    end
    check_lit("wrap_model_cnt", m_cnt, 0);
    run_instr(0, 1'b0, 0, 1'b1, 8'd0, 0, st, wn);
    hold_done(1);
    check_lit("wrap_plus_one", retired_count, 1);
    reset = 1'b1;
    reset_seq();

    // Random mix: stalls, LSU latency, occasional timeouts, RETs, aborts.
    idle_cycles($urandom_range(0, 3));
    start = 1'b1;
    for (int k = 0; k < 60; k++) begin
      int busy;
      int abort_st;
      busy     = ($urandom_range(0, 9) == 0) ? 70 : $urandom_range(0, 6);
      abort_st = ($urandom_range(0, 19) == 0) ? $urandom_range(1, 6) : 0;
      run_instr($urandom_range(0, 3), 1'($urandom_range(0, 1)), busy,
                ($urandom_range(0, 15) == 0), 8'($urandom_range(0, 255)),
                abort_st, st, wn);
      if (st == 1 || st == 2) begin
        hold_done($urandom_range(1, 4));
        reset = 1'b1;
      end
      if (st != 0) begin
        reset_seq();
        idle_cycles($urandom_range(0, 2));
        start = 1'b1;
      end
    end

    @(negedge clk);
    @(negedge clk);
    check_lit("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
